// File: rtl/snake_pkg.sv
// Purpose: shared screen/result types and defaults for the snake display path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package snake_pkg;

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    GAME  = 3'd1,
    WIN   = 3'd2,
    LOSE  = 3'd3,
    DRAW  = 3'd4,
    ERROR = 3'd5
  } game_mode;

  typedef enum logic [1:0] {
    RES_WIN  = 2'd0,
    RES_LOSE = 2'd1,
    RES_DRAW = 2'd2
  } game_result_e;

  // Frames an end screen stays up before a click may dismiss it (2 s at 60 Hz).
  localparam int HOLD_FRAMES_DEF = 120;

  // End screens are the ones that wait for an acknowledging click.
  function automatic logic is_screen(input game_mode m);
    return (m == WIN) || (m == LOSE) || (m == DRAW) || (m == ERROR);
  endfunction

  // Maps a finished-game outcome onto the screen that announces it.
  function automatic game_mode result_to_mode(input game_result_e r);
    game_mode m;
    case (r)
      RES_WIN:  m = WIN;
      RES_LOSE: m = LOSE;
      default:  m = DRAW;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Purpose: VGA timing stream bundle; this block only consumes the vertical blank.
// Latency: n/a (wires only).
// Backpressure: none, the timing stream free-runs.
interface vga_if;
  logic vblnk;
  modport in  (input  vblnk);
  modport out (output vblnk);
endinterface

// File: rtl/frame_edge_det.sv
// Purpose: rising-edge detector on a level, used to find the start of vertical blank.
// Latency: combinational pulse in the cycle the level is first seen high.
// Backpressure: none; a level already high when reset releases is not an edge.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;
  logic r_low_seen;

  // Track the previous level and whether a low level has been seen since reset,
  // so a level held high across reset release cannot masquerade as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_q  <= 1'b0;
      r_low_seen <= ~i_level;
    end else begin
      r_level_q  <= i_level;
      r_low_seen <= r_low_seen | ~i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q & r_low_seen;

endmodule

// File: rtl/draw_mode_ctrl.sv
// Purpose: screen-mode FSM (menu/game/end screens) stepping only on frame boundaries.
// Latency: requests latch on arrival; mode/game_run change 1 cycle after the vblnk rise.
// Backpressure: none; pending bits hold requests until the next frame edge.
module draw_mode_ctrl
  import snake_pkg::*;
#(
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int HOLD_W      = 8    // must satisfy HOLD_FRAMES < 2**HOLD_W
) (
  input  logic         clk,
  input  logic         rst,
  vga_if.in            vga_in,
  input  logic         start_req,
  input  logic         click,
  input  logic         result_valid,
  input  game_result_e result,
  input  logic         error_req,
  output game_mode     mode,
  output logic         game_run,
  output logic         frame_tick
);

  localparam logic [HOLD_W-1:0] LP_HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  game_mode          r_state;
  logic              r_pend_start;
  logic              r_pend_res;
  game_result_e      r_pend_res_val;
  logic              r_pend_click;
  logic              r_pend_err;
  logic [HOLD_W-1:0] r_hold;
  logic              r_game_run;
  logic              r_frame_tick;

  logic              w_frame_edge;
  logic              w_screen;
  logic              w_hold_done;
  logic              w_start;
  logic              w_res;
  game_result_e      w_res_val;
  logic              w_click;
  logic              w_err;
  game_mode          w_next;

  frame_edge_det u_frame_edge_det (
    .clk     (clk),
    .rst     (rst),
    .i_level (vga_in.vblnk),
    .o_rise  (w_frame_edge)
  );

  // Merge stored requests with this cycle's arrivals (so a request coincident
  // with the edge still counts), then pick the next state on a frame edge.
  always_comb begin
    w_screen    = is_screen(r_state);
    w_hold_done = (r_hold == LP_HOLD_MAX);
    w_start     = r_pend_start | (start_req & (r_state == MENU));
    w_res       = r_pend_res | (result_valid & (r_state == GAME));
    w_res_val   = (result_valid && (r_state == GAME)) ? result : r_pend_res_val;
    w_click     = r_pend_click | (click & w_screen & w_hold_done);
    w_err       = r_pend_err | (error_req & (r_state != ERROR));
    w_next      = r_state;
    if (w_frame_edge) begin
      if (w_err) begin
        w_next = ERROR;
      end else begin
        case (r_state)
          MENU:                  if (w_start) w_next = GAME;
          GAME:                  if (w_res)   w_next = result_to_mode(w_res_val);
          WIN, LOSE, DRAW, ERROR: if (w_click) w_next = MENU;
          default:               w_next = MENU;
        endcase
      end
    end
  end

  // State, pending requests and end-screen hold counter. Every state change
  // drops all pending bits: the consumed one is done and the rest are invalid
  // in the new state (error never survives into ERROR).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= MENU;
      r_pend_start   <= 1'b0;
      r_pend_res     <= 1'b0;
      r_pend_res_val <= RES_WIN;
      r_pend_click   <= 1'b0;
      r_pend_err     <= 1'b0;
      r_hold         <= '0;
    end else if (w_next != r_state) begin
      r_state        <= w_next;
      r_pend_start   <= 1'b0;
      r_pend_res     <= 1'b0;
      r_pend_click   <= 1'b0;
      r_pend_err     <= 1'b0;
      r_hold         <= '0;
    end else begin
      r_pend_start   <= w_start;
      r_pend_res     <= w_res;
      r_pend_res_val <= w_res_val;
      r_pend_click   <= w_click;
      r_pend_err     <= w_err;
      if (w_frame_edge && w_screen && !w_hold_done) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  // Registered outputs: game_run looks at the next state so it moves with mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_game_run   <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_game_run   <= (w_next == GAME);
      r_frame_tick <= w_frame_edge;
    end
  end

  assign mode       = r_state;
  assign game_run   = r_game_run;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_draw_mode_ctrl.sv
// Purpose: directed bench for draw_mode_ctrl with an expected-mode queue per frame edge.
// Latency: expects mode/game_run/frame_tick updated one cycle after each vblnk rise.
// Backpressure: n/a; inputs are pulses, outputs sampled 1 time unit after posedge.
module tb_draw_mode_ctrl;
  import snake_pkg::*;

  localparam int LOW_CYC  = 3;
  localparam int HIGH_CYC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_req;
  logic         click;
  logic         result_valid;
  game_result_e result;
  logic         error_req;
  game_mode     mode;
  logic         game_run;
  logic         frame_tick;

  vga_if u_vga ();

  int errors   = 0;
  int checks   = 0;
  int rise_cnt = 0;
  int tick_cnt = 0;

  game_mode exp_q[$];
  game_mode cur_mode;

  always #5 clk = ~clk;

  draw_mode_ctrl #(.HOLD_FRAMES(120), .HOLD_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (u_vga),
    .start_req    (start_req),
    .click        (click),
    .result_valid (result_valid),
    .result       (result),
    .error_req    (error_req),
    .mode         (mode),
    .game_run     (game_run),
    .frame_tick   (frame_tick)
  );

  // Count frame_tick pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_cnt++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input logic [3:0] req, input game_result_e res);
    {start_req, click, result_valid, error_req} = req;
    result = res;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'(cur_mode));
    chk({tag, "_run"},  32'(game_run), 32'(cur_mode == GAME));
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  // One-cycle request pulse away from any frame edge; mode must not move.
  task automatic pulse(input logic [3:0] req, input game_result_e res, input string tag);
    set_reqs(req, res);
    tick();
    set_reqs(4'b0000, RES_WIN);
    idle_chk(tag);
  endtask

  // One full frame: vblnk low, then a rise (optionally with requests in that
  // same cycle). The expected mode is queued at the rise and popped once the
  // DUT has had its cycle to react.
  task automatic frame(input game_mode exp_m, input logic [3:0] req, input game_result_e res,
                       input string tag);
    game_mode e;
    u_vga.vblnk = 1'b0;
    repeat (LOW_CYC) begin
      tick();
      idle_chk(tag);
    end
    u_vga.vblnk = 1'b1;
    set_reqs(req, res);
    exp_q.push_back(exp_m);
    rise_cnt++;
    tick();
    set_reqs(4'b0000, RES_WIN);
    e = exp_q.pop_front();
    chk({tag, "_edge_mode"}, 32'(mode), 32'(e));
    chk({tag, "_edge_run"},  32'(game_run), 32'(e == GAME));
    chk({tag, "_edge_tick"}, 32'(frame_tick), 32'd1);
    cur_mode = e;
    repeat (HIGH_CYC - 1) begin
      tick();
      idle_chk(tag);
    end
  endtask

  initial begin
    rst         = 1'b1;
    u_vga.vblnk = 1'b1;
    set_reqs(4'b0000, RES_WIN);
    cur_mode    = MENU;

    // Reset with vblnk high; a start pulse during reset must be dropped.
    repeat (3) tick();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    chk("rst_mode", 32'(mode), 32'(MENU));
    chk("rst_run",  32'(game_run), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_hold", 32'(dut.r_hold), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      idle_chk("release_vblnk_high");
    end
    frame(MENU, 4'b0000, RES_WIN, "first_frame");

    // Start mid-frame: MENU until the rise, GAME right after it.
    pulse(4'b1000, RES_WIN, "start_mid");
    frame(GAME, 4'b0000, RES_WIN, "to_game");

    // Lose, then clicks at hold 10 and 119 are dropped; at 120 it returns.
    pulse(4'b0010, RES_LOSE, "res_lose");
    frame(LOSE, 4'b0000, RES_WIN, "to_lose");
    repeat (10) frame(LOSE, 4'b0000, RES_WIN, "lose_hold");
    pulse(4'b0100, RES_WIN, "click_early");
    frame(LOSE, 4'b0000, RES_WIN, "click_early_ignored");
    repeat (108) frame(LOSE, 4'b0000, RES_WIN, "lose_hold2");
    pulse(4'b0100, RES_WIN, "click_119");
    frame(LOSE, 4'b0000, RES_WIN, "click_119_ignored");
    chk("hold_sat_120", 32'(dut.r_hold), 32'd120);
    pulse(4'b0100, RES_WIN, "click_120");
    frame(MENU, 4'b0000, RES_WIN, "lose_to_menu");

    // Error and win together: error wins.
    pulse(4'b1000, RES_WIN, "start2");
    frame(GAME, 4'b0000, RES_WIN, "to_game2");
    pulse(4'b0011, RES_WIN, "win_and_err");
    frame(ERROR, 4'b0000, RES_WIN, "err_priority");
    pulse(4'b0001, RES_WIN, "err_in_error");
    repeat (120) frame(ERROR, 4'b0000, RES_WIN, "err_hold");
    pulse(4'b0100, RES_WIN, "err_click");
    frame(MENU, 4'b0000, RES_WIN, "err_to_menu");

    // Requests coincident with the frame edge apply at that edge.
    frame(GAME, 4'b1000, RES_WIN, "start_at_edge");
    frame(DRAW, 4'b0010, RES_DRAW, "draw_at_edge");
    repeat (50) frame(DRAW, 4'b0000, RES_WIN, "draw_hold");
    chk("hold_50", 32'(dut.r_hold), 32'd50);

    // One-cycle reset in DRAW with vblnk high; error during reset is dropped.
    rst       = 1'b1;
    error_req = 1'b1;
    tick();
    rst       = 1'b0;
    error_req = 1'b0;
    cur_mode  = MENU;
    chk("rst2_mode", 32'(mode), 32'(MENU));
    chk("rst2_run",  32'(game_run), 32'd0);
    chk("rst2_tick", 32'(frame_tick), 32'd0);
    chk("rst2_hold", 32'(dut.r_hold), 32'd0);
    repeat (3) begin
      tick();
      idle_chk("rst2_no_edge");
    end
    frame(MENU, 4'b0000, RES_WIN, "rst_err_dropped");

    // Two starts in one frame give one transition.
    pulse(4'b1000, RES_WIN, "start_a");
    tick();
    idle_chk("between_starts");
    pulse(4'b1000, RES_WIN, "start_b");
    frame(GAME, 4'b0000, RES_WIN, "double_start");
    frame(GAME, 4'b0000, RES_WIN, "double_start_once");

    while (rise_cnt < 300) frame(cur_mode, 4'b0000, RES_WIN, "fill");

    tick();
    chk("tick_vs_rise", 32'(tick_cnt), 32'(rise_cnt));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
